// File: rtl/dual_countdown_pkg.sv
// Shared definitions for the two-player countdown clock: FSM states, player codes
// and the seconds rollover value.
package dual_countdown_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } state_t;

  localparam logic [1:0] P1      = 2'b01;
  localparam logic [1:0] P2      = 2'b10;
  localparam logic [5:0] SEC_MAX = 6'd59;

  function automatic logic valid_player(input logic [1:0] p);
    return (p == P1) || (p == P2);
  endfunction

endpackage

// File: rtl/mmss_counter.sv
// One player's mm:ss register with preset, borrow-style decrement and a zero flag.
module mmss_counter
  import dual_countdown_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [5:0] load_min,
  input  logic       dec,
  output logic [5:0] min,
  output logic [5:0] sec,
  output logic       is_zero
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      min <= '0;
      sec <= '0;
    end else if (load) begin
      min <= load_min;
      sec <= '0;
    end else if (dec) begin
      if (sec != '0) begin
        sec <= sec - 6'd1;
      end else if (min != '0) begin
        sec <= SEC_MAX;
        min <= min - 6'd1;
      end
    end
  end

  assign is_zero = (min == '0) && (sec == '0);

endmodule

// File: rtl/dual_countdown.sv
// Two-player countdown clock: one-second prescaler, IDLE/RUN/EXPIRED control and
// two mm:ss counters of which only the selected player's one decrements.
module dual_countdown
  import dual_countdown_pkg::*;
#(
  parameter int CLK_HZ  = 100000000,
  parameter int MAX_MIN = 59
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       enable,
  input  logic [5:0] time_in,
  input  logic [1:0] player,
  output logic [5:0] min1,
  output logic [5:0] sec1,
  output logic [5:0] min2,
  output logic [5:0] sec2,
  output logic       flag1,
  output logic       flag2,
  output logic       tick
);

  localparam int            PW      = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PS_TERM = PW'(CLK_HZ - 1);

  state_t        state, state_next;
  logic [PW-1:0] prescaler;
  logic [1:0]    prev_player;
  logic [5:0]    load_min;
  logic          player_ok, player_change;
  logic          count_en, wrap, dec1, dec2, expire1, expire2, zero1, zero2;

  assign player_ok     = valid_player(player);
  assign player_change = (prev_player != player);
  assign load_min      = (time_in > 6'(MAX_MIN)) ? 6'(MAX_MIN) : time_in;

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned and infers a latch.
  always_comb begin
    state_next = state;
    if (load) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (enable && player_ok) state_next = RUN;
        RUN:     if (expire1 || expire2)  state_next = EXPIRED;
        default: state_next = state;
      endcase
    end
  end

  // A tick at 00:00 expires the running player instead of decrementing it.
  always_comb begin
    count_en = 1'b0;
    wrap     = 1'b0;
    dec1     = 1'b0;
    dec2     = 1'b0;
    expire1  = 1'b0;
    expire2  = 1'b0;
    if (!load && state == RUN && enable && player_ok && !player_change) begin
      count_en = 1'b1;
      if (prescaler == PS_TERM) begin
        wrap = 1'b1;
        if (player == P1) begin
          if (zero1) expire1 = 1'b1;
          else       dec1    = 1'b1;
        end else begin
          if (zero2) expire2 = 1'b1;
          else       dec2    = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      prescaler   <= '0;
      prev_player <= 2'b00;
      tick        <= 1'b0;
      flag1       <= 1'b0;
      flag2       <= 1'b0;
    end else begin
      prev_player <= player;
      tick        <= wrap;
      if (load || player_change) prescaler <= '0;
      else if (count_en)         prescaler <= wrap ? '0 : prescaler + PW'(1);
      if (load) begin
        flag1 <= 1'b0;
        flag2 <= 1'b0;
      end else begin
        if (expire1) flag1 <= 1'b1;
        if (expire2) flag2 <= 1'b1;
      end
    end
  end

  mmss_counter u_p1 (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .load_min(load_min),
    .dec     (dec1),
    .min     (min1),
    .sec     (sec1),
    .is_zero (zero1)
  );

  mmss_counter u_p2 (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .load_min(load_min),
    .dec     (dec2),
    .min     (min2),
    .sec     (sec2),
    .is_zero (zero2)
  );

endmodule

// File: tb/tb_dual_countdown.sv
// Directed bench for dual_countdown with a 4-cycle second: table-driven timeline
// followed by hand-written pause, clamp, expiry and reset sequences.
module tb_dual_countdown;
  import dual_countdown_pkg::*;

  logic       clk = 1'b0;
  logic       reset, load, enable;
  logic [5:0] time_in;
  logic [1:0] player;
  logic [5:0] min1, sec1, min2, sec2;
  logic       flag1, flag2, tick;

  int checks = 0;
  int errors = 0;

  dual_countdown #(.CLK_HZ(4), .MAX_MIN(59)) dut (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .enable (enable),
    .time_in(time_in),
    .player (player),
    .min1   (min1),
    .sec1   (sec1),
    .min2   (min2),
    .sec2   (sec2),
    .flag1  (flag1),
    .flag2  (flag2),
    .tick   (tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, ld, en;
    logic [5:0] t;
    logic [1:0] p;
    logic [5:0] m1, s1, m2, s2;
    logic       f1, f2, tk;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input logic r, input logic l, input logic e,
                       input logic [5:0] t, input logic [1:0] p);
    reset   = r;
    load    = l;
    enable  = e;
    time_in = t;
    player  = p;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input logic [5:0] m1, input logic [5:0] s1,
                            input logic [5:0] m2, input logic [5:0] s2,
                            input logic f1, input logic f2, input logic tk);
    check(name, 32'({min1, sec1, min2, sec2, flag1, flag2, tick}),
                32'({m1, s1, m2, s2, f1, f2, tk}));
  endtask

  task automatic expect_state(input string name, input state_t s);
    check(name, 32'(dut.state), 32'(s));
  endtask

  initial begin
    reset = 1'b0; load = 1'b0; enable = 1'b0; time_in = '0; player = 2'b00;

    // Reset, load 2 min, player 1 runs one second, then switch to player 2 at prescaler=2.
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 6'd0, 2'b00, 6'd0, 6'd0,  6'd0, 6'd0,  1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 1'b1, 6'd2, 2'b01, 6'd2, 6'd0,  6'd2, 6'd0,  1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b1, 6'd0, 2'b01, 6'd2, 6'd0,  6'd2, 6'd0,  1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 1'b1, 6'd0, 2'b01, 6'd2, 6'd0,  6'd2, 6'd0,  1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 1'b1, 6'd0, 2'b01, 6'd2, 6'd0,  6'd2, 6'd0,  1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 1'b1, 6'd0, 2'b01, 6'd2, 6'd0,  6'd2, 6'd0,  1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 1'b1, 6'd0, 2'b01, 6'd1, 6'd59, 6'd2, 6'd0,  1'b0, 1'b0, 1'b1};
    vecs[7]  = '{1'b1, 1'b0, 1'b1, 6'd0, 2'b01, 6'd1, 6'd59, 6'd2, 6'd0,  1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 1'b1, 6'd0, 2'b01, 6'd1, 6'd59, 6'd2, 6'd0,  1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 6'd0, 2'b10, 6'd1, 6'd59, 6'd2, 6'd0,  1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 1'b1, 6'd0, 2'b10, 6'd1, 6'd59, 6'd2, 6'd0,  1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 1'b1, 6'd0, 2'b10, 6'd1, 6'd59, 6'd2, 6'd0,  1'b0, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 1'b1, 6'd0, 2'b10, 6'd1, 6'd59, 6'd2, 6'd0,  1'b0, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 1'b0, 1'b1, 6'd0, 2'b10, 6'd1, 6'd59, 6'd1, 6'd59, 1'b0, 1'b0, 1'b1};

    for (int i = 0; i < 14; i++) begin
      apply(vecs[i].rst, vecs[i].ld, vecs[i].en, vecs[i].t, vecs[i].p);
      expect_out($sformatf("vec%0d", i), vecs[i].m1, vecs[i].s1, vecs[i].m2, vecs[i].s2,
                 vecs[i].f1, vecs[i].f2, vecs[i].tk);
      if (i == 0) expect_state("reset_state", IDLE);
      if (i == 2) expect_state("idle_to_run", RUN);
    end

    // Pause with prescaler at 2: no ticks, values held, then resume from 2.
    repeat (2) apply(1'b1, 1'b0, 1'b1, 6'd0, 2'b10);
    expect_out("pre_pause", 6'd1, 6'd59, 6'd1, 6'd59, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      apply(1'b1, 1'b0, 1'b0, 6'd0, 2'b10);
      expect_out($sformatf("pause%0d", i), 6'd1, 6'd59, 6'd1, 6'd59, 1'b0, 1'b0, 1'b0);
    end
    expect_state("pause_stays_run", RUN);
    apply(1'b1, 1'b0, 1'b1, 6'd0, 2'b10);
    expect_out("resume_ps3", 6'd1, 6'd59, 6'd1, 6'd59, 1'b0, 1'b0, 1'b0);
    apply(1'b1, 1'b0, 1'b1, 6'd0, 2'b10);
    expect_out("resume_tick", 6'd1, 6'd59, 6'd1, 6'd58, 1'b0, 1'b0, 1'b1);

    // Bring prescaler to its terminal value, then load on the would-be tick edge.
    repeat (3) apply(1'b1, 1'b0, 1'b1, 6'd0, 2'b10);
    expect_out("before_load_tick", 6'd1, 6'd59, 6'd1, 6'd58, 1'b0, 1'b0, 1'b0);
    apply(1'b1, 1'b1, 1'b1, 6'd63, 2'b10);
    expect_out("load_clamp", 6'd59, 6'd0, 6'd59, 6'd0, 1'b0, 1'b0, 1'b0);
    expect_state("load_idle", IDLE);

    // Zero preset for player 2: first tick in RUN expires it.
    apply(1'b1, 1'b1, 1'b1, 6'd0, 2'b10);
    expect_out("load_zero", 6'd0, 6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0);
    apply(1'b1, 1'b0, 1'b1, 6'd0, 2'b10);
    for (int i = 0; i < 4; i++) begin
      apply(1'b1, 1'b0, 1'b1, 6'd0, 2'b10);
      check($sformatf("flag2_run%0d", i), 32'(flag2), 32'(i == 3));
    end
    expect_state("p2_expired", EXPIRED);
    for (int i = 0; i < 8; i++) begin
      apply(1'b1, 1'b0, 1'b1, 6'd0, (i % 2 == 0) ? 2'b01 : 2'b10);
      expect_out($sformatf("frozen%0d", i), 6'd0, 6'd0, 6'd0, 6'd0, 1'b0, 1'b1, 1'b0);
    end
    expect_state("still_expired", EXPIRED);

    // Reset wins over a coincident load while EXPIRED.
    apply(1'b0, 1'b1, 1'b1, 6'd5, 2'b01);
    expect_out("reset_over_load", 6'd0, 6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0);
    expect_state("reset_idle", IDLE);

    // Player 1 expiry sets flag1 only; a later load clears it.
    apply(1'b1, 1'b1, 1'b1, 6'd0, 2'b01);
    apply(1'b1, 1'b0, 1'b1, 6'd0, 2'b01);
    for (int i = 0; i < 4; i++) begin
      apply(1'b1, 1'b0, 1'b1, 6'd0, 2'b01);
      check($sformatf("flag1_run%0d", i), 32'({flag1, flag2}), (i == 3) ? 32'd2 : 32'd0);
    end
    apply(1'b1, 1'b1, 1'b0, 6'd1, 2'b00);
    expect_out("load_clears_flag", 6'd1, 6'd0, 6'd1, 6'd0, 1'b0, 1'b0, 1'b0);
    expect_state("load_leaves_expired", IDLE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
